// File: rtl/clock_divider_prog_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Exports div_t, MIN_DIV and half_hi() (high-phase length of a period).
package clkdiv_pkg;

    parameter int DIV_W = 8;

    typedef logic [DIV_W-1:0] div_t;

    localparam int MIN_DIV = 2;

    // Number of high cycles in an N-cycle period: ceil(N/2).
    function automatic int unsigned half_hi(input int unsigned n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/clock_divider_prog_if.sv
// Divisor-load bus of the programmable clock divider.
// master: LoadValid/LoadCh/LoadDiv out, LoadErr/Pending in; slave: reverse.
interface clock_divider_prog_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              LoadValid;
    logic [CH_W-1:0]   LoadCh;
    logic [CNT_W-1:0]  LoadDiv;
    logic              LoadErr;
    logic [NUM_CH-1:0] Pending;

    modport master (
        output LoadValid, LoadCh, LoadDiv,
        input  LoadErr, Pending
    );

    modport slave (
        input  LoadValid, LoadCh, LoadDiv,
        output LoadErr, Pending
    );
endinterface

// File: rtl/clock_divider_prog_channel.sv
// One divider channel: phase counter, active/shadow divisor, flopped outputs.
// Ports: clk_i, rst_i, en_i, wr_i/div_i (legal write), clk_o, tick_o, pend_o.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pend_o
);
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] hi;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             at_bnd;

    always_comb begin
        at_bnd   = (phase_q == '0);
        shadow_d = wr_i ? div_i : shadow_q;
        // At a boundary the freshest divisor (a same-edge write included)
        // becomes active and already shapes this edge's outputs.
        active_d = at_bnd ? shadow_d : active_q;
        pend_d   = at_bnd ? 1'b0 : (pend_q | wr_i);
        hi       = CNT_W'(half_hi(32'(active_d)));
        clk_d    = 1'b0;
        tick_d   = 1'b0;
        phase_d  = '0;
        if (en_i) begin
            clk_d   = (phase_q < hi);
            tick_d  = at_bnd;
            phase_d = (phase_q == active_d - CNT_W'(1))
                    ? '0 : phase_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q  <= '0;
            active_q <= CNT_W'(DEFAULT_DIV);
            shadow_q <= CNT_W'(DEFAULT_DIV);
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign pend_o = pend_q;
endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable integer clock divider (top level).
// Ports: ClkIn, Reset, Enable, ClkOut, Tick, bus (LoadValid/Ch/Div, LoadErr, Pending).
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                ClkIn,
    input  logic                Reset,
    input  logic [NUM_CH-1:0]   Enable,
    output logic [NUM_CH-1:0]   ClkOut,
    output logic [NUM_CH-1:0]   Tick,
    clock_divider_prog_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              legal;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] pend;

    always_comb begin
        legal = bus.LoadValid
              && (int'(bus.LoadCh) < NUM_CH)
              && (bus.LoadDiv >= CNT_W'(MIN_DIV));
        err_d = bus.LoadValid && !legal;
    end

    always_ff @(posedge ClkIn or posedge Reset) begin
        if (Reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.LoadErr = err_q;
    assign bus.Pending = pend;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_i  (ClkIn),
            .rst_i  (Reset),
            .en_i   (Enable[g]),
            .wr_i   (legal && (bus.LoadCh == CH_W'(g))),
            .div_i  (bus.LoadDiv),
            .clk_o  (ClkOut[g]),
            .tick_o (Tick[g]),
            .pend_o (pend[g])
        );
    end
endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog (3 channels, CNT_W=8, DEFAULT_DIV=2).
// Stimulus queues hand-computed {ClkOut,Tick,Pending,LoadErr}; a monitor compares.
module tb_clock_divider_prog;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [9:0] v;
        string      nm;
    } exp_t;

    logic              ClkIn;
    logic              Reset;
    logic [NUM_CH-1:0] Enable;
    logic [NUM_CH-1:0] ClkOut;
    logic [NUM_CH-1:0] Tick;

    clock_divider_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clock_divider_prog #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (2)
    ) dut (
        .ClkIn  (ClkIn),
        .Reset  (Reset),
        .Enable (Enable),
        .ClkOut (ClkOut),
        .Tick   (Tick),
        .bus    (bus)
    );

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    initial begin
        ClkIn = 1'b0;
        forever #5 ClkIn = ~ClkIn;
    end

    function automatic logic [9:0] obs();
        return {ClkOut, Tick, bus.Pending, bus.LoadErr};
    endfunction

    task automatic chk(input string nm, input logic [9:0] got,
                       input logic [9:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got clk=%b tick=%b pend=%b err=%b, want clk=%b tick=%b pend=%b err=%b",
                      nm, got[9:7], got[6:4], got[3:1], got[0],
                      exp[9:7], exp[6:4], exp[3:1], exp[0]);
    endtask

    // Monitor: outputs are valid every cycle; compare just after each edge.
    always @(posedge ClkIn) begin
        exp_t e;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, obs(), e.v);
        end
    end

    // One clock edge with the inputs currently driven; queue its expected result.
    task automatic cyc(input logic [2:0] c, input logic [2:0] t,
                       input logic [2:0] p, input logic e, input string nm);
        @(posedge ClkIn);
        q.push_back('{v: {c, t, p, e}, nm: nm});
        @(negedge ClkIn);
    endtask

    task automatic wr(input logic v, input logic [1:0] ch,
                      input logic [7:0] d);
        bus.LoadValid = v;
        bus.LoadCh    = ch;
        bus.LoadDiv   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset  = 1'b1;
        Enable = '0;
        wr(1'b0, 2'd0, 8'd0);
        #3;
        chk("reset_async", obs(), 10'b0);
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "reset_hold");
        Reset = 1'b0;

        // N=2 on ch0, legacy toggle; ch1/ch2 idle
        Enable = 3'b001;
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "n2_c0");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n2_c1");
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "n2_c2");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n2_c3");
        Enable = 3'b000;
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n2_off");

        // N=3 written while disabled: adopted at once, Pending stays low
        wr(1'b1, 2'd0, 8'd3);
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n3_wr");
        wr(1'b0, 2'd0, 8'd0);
        Enable = 3'b001;
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "n3_c0");
        cyc(3'b001, 3'b000, 3'b000, 1'b0, "n3_c1");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n3_c2");
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "n3_c3");
        cyc(3'b001, 3'b000, 3'b000, 1'b0, "n3_c4");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n3_c5");
        Enable = 3'b000;
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n3_off");

        // N=4 running, write N=5 at phase 1: old period completes first
        wr(1'b1, 2'd0, 8'd4);
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n4_wr");
        wr(1'b0, 2'd0, 8'd0);
        Enable = 3'b001;
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "n4_p0");
        wr(1'b1, 2'd0, 8'd5);
        cyc(3'b001, 3'b000, 3'b001, 1'b0, "n4_p1_wr5");
        wr(1'b0, 2'd0, 8'd0);
        cyc(3'b000, 3'b000, 3'b001, 1'b0, "n4_p2");
        cyc(3'b000, 3'b000, 3'b001, 1'b0, "n4_p3");
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "n5_p0");
        cyc(3'b001, 3'b000, 3'b000, 1'b0, "n5_p1");
        cyc(3'b001, 3'b000, 3'b000, 1'b0, "n5_p2");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n5_p3");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n5_p4");
        Enable = 3'b000;
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n5_off");

        // Rejected writes: one-cycle LoadErr, divisor untouched
        wr(1'b1, 2'd0, 8'd1);
        cyc(3'b000, 3'b000, 3'b000, 1'b1, "err_div1");
        wr(1'b0, 2'd0, 8'd0);
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "err_div1_end");
        wr(1'b1, 2'd0, 8'd0);
        cyc(3'b000, 3'b000, 3'b000, 1'b1, "err_div0");
        wr(1'b0, 2'd0, 8'd0);
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "err_div0_end");
        wr(1'b1, 2'd3, 8'd6);
        cyc(3'b000, 3'b000, 3'b000, 1'b1, "err_ch3");
        wr(1'b0, 2'd0, 8'd0);
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "err_ch3_end");
        Enable = 3'b001;
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "keep5_p0");
        cyc(3'b001, 3'b000, 3'b000, 1'b0, "keep5_p1");
        cyc(3'b001, 3'b000, 3'b000, 1'b0, "keep5_p2");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "keep5_p3");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "keep5_p4");
        Enable = 3'b000;
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "keep5_off");

        // N=6, drop Enable mid-high, re-enable restarts a fresh period
        wr(1'b1, 2'd0, 8'd6);
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n6_wr");
        wr(1'b0, 2'd0, 8'd0);
        Enable = 3'b001;
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "n6_a0");
        cyc(3'b001, 3'b000, 3'b000, 1'b0, "n6_a1");
        Enable = 3'b000;
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n6_drop");
        Enable = 3'b001;
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "n6_b0");
        cyc(3'b001, 3'b000, 3'b000, 1'b0, "n6_b1");
        cyc(3'b001, 3'b000, 3'b000, 1'b0, "n6_b2");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n6_b3");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n6_b4");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "n6_b5");

        // Pending write, then async reset mid-period discards it
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "rst_p0");
        wr(1'b1, 2'd0, 8'd7);
        cyc(3'b001, 3'b000, 3'b001, 1'b0, "rst_p1_wr7");
        wr(1'b0, 2'd0, 8'd0);
        #2;
        Reset = 1'b1;
        #1;
        chk("reset_mid", obs(), 10'b0);
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "rst_held");
        Reset = 1'b0;
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "post_rst_c0");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "post_rst_c1");
        cyc(3'b001, 3'b001, 3'b000, 1'b0, "post_rst_c2");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, "post_rst_c3");

        @(posedge ClkIn);
        #3;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d queued, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
